main_data_router: RTL

- Parametrised successor to the single-frame MP3 main-data bit muxer.
- Sits between the bit-reservoir FIFO (first-word-fall-through, 1 bit per pop) and the scalefactor parser / Huffman decoder.
- Per frame: discards stale reservoir bits, then routes exactly part2_3_length bits per granule/channel, first to the SF parser and then to the Huffman decoder.
- New relative to the previous block: configurable granule/channel count, runtime mono mode, byte-based main_data_begin, exact bit accounting with no off-by-one, zero-length granules, abort/skip pulses.

---
 rtl/main_data_router.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/main_data_router.sv
// main_data_router: routes bit-reservoir FIFO bits to discard, scalefactor parser and Huffman decoder per granule/channel
// Ports: clk/rst (sync, active-high); fifo_sample_count, fifo_dout_v from the FWFT reservoir FIFO;
// si_valid_in, main_data_begin, mono, part2_3_length, sf_done from side info and the SF parser;
// res_discard_flag, sf_parser_flag, hf_decoder_flag pop the FIFO head; gr, ch, busy, frame_done, frame_skip status.
// Optional ROUTER_STATS_EN adds skip_count (saturating) and discard_total (wrapping).
module main_data_router #(
  parameter int NUM_GR = 2,
  parameter int NUM_CH = 2,
  parameter int CNT_W = 16,
  parameter int P23_W = 12,
  parameter int MDB_W = 9,
  localparam int GR_W = NUM_GR > 1 ? $clog2(NUM_GR) : 1,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1,
  localparam int N = NUM_GR * NUM_CH,
  localparam int IDX_W = N > 1 ? $clog2(N) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic [CNT_W-1:0] fifo_sample_count,
  input  logic fifo_dout_v,
  input  logic si_valid_in,
  input  logic [MDB_W-1:0] main_data_begin,
  input  logic mono,
  input  logic [N*P23_W-1:0] part2_3_length,
  input  logic [N-1:0] sf_done,
  output logic res_discard_flag,
  output logic sf_parser_flag,
  output logic hf_decoder_flag,
  output logic [GR_W-1:0] gr,
  output logic [CH_W-1:0] ch,
  output logic busy,
  output logic frame_done,
  output logic frame_skip
`ifdef ROUTER_STATS_EN
  ,
  output logic [15:0] skip_count,
  output logic [CNT_W-1:0] discard_total
`endif
);
  typedef enum logic [2:0] {IDLE, DISCARD, HOLD, SF, HUFF} state_t;
  state_t state_q, state_d;
  logic [GR_W-1:0] gr_q, gr_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [CNT_W-1:0] disc_cnt_q, disc_cnt_d, num_disc_q, num_disc_d, need;
  logic [P23_W-1:0] bit_cnt_q, bit_cnt_d, target;
  logic [N*P23_W-1:0] p23_q, p23_d;
  logic mono_q, mono_d, frame_done_q, frame_done_d, frame_skip_q, frame_skip_d;
  logic [IDX_W-1:0] idx;
  logic adv, last, under;
  assign idx = IDX_W'(32'(gr_q) * NUM_CH + 32'(ch_q));
  assign target = p23_q[idx*P23_W +: P23_W];
  assign need = CNT_W'(main_data_begin) << 3;
  assign under = fifo_sample_count < need;
  assign last = gr_q == GR_W'(NUM_GR - 1) && (mono_q || ch_q == CH_W'(NUM_CH - 1));
  // a new side-info pulse suppresses all pops so no stray bit leaves the FIFO during the restart
  assign res_discard_flag = !si_valid_in && state_q == DISCARD && disc_cnt_q < num_disc_q;
  assign sf_parser_flag = !si_valid_in && state_q == SF && !sf_done[idx] && bit_cnt_q < target;
  assign hf_decoder_flag = !si_valid_in && state_q == HUFF && bit_cnt_q < target;
  assign gr = gr_q;
  assign ch = ch_q;
  assign busy = state_q != IDLE;
  assign frame_done = frame_done_q;
  assign frame_skip = frame_skip_q;
  always_comb begin
    state_d = state_q;
    gr_d = gr_q;
    ch_d = ch_q;
    p23_d = p23_q;
    mono_d = mono_q;
    num_disc_d = num_disc_q;
    frame_done_d = 1'b0;
    frame_skip_d = 1'b0;
    adv = 1'b0;
    disc_cnt_d = disc_cnt_q + CNT_W'(res_discard_flag && fifo_dout_v);
    bit_cnt_d = bit_cnt_q + P23_W'((sf_parser_flag || hf_decoder_flag) && fifo_dout_v);
    if (si_valid_in) begin
      p23_d = part2_3_length;
      mono_d = mono;
      gr_d = '0;
      ch_d = '0;
      disc_cnt_d = '0;
      bit_cnt_d = '0;
      frame_skip_d = state_q != IDLE || under;
      num_disc_d = under ? '0 : fifo_sample_count - need;
      state_d = under ? IDLE : fifo_sample_count != need ? DISCARD : HOLD;
    end else begin
      case (state_q)
        DISCARD: if (disc_cnt_d == num_disc_q) state_d = HOLD;
        HOLD: begin
          if (target == '0) adv = 1'b1;
          else if (32'(fifo_sample_count) >= 32'(target)) begin
            state_d = SF;
            bit_cnt_d = '0;
          end
        end
        // comparing the post-pop count lets the slot close on its final bit without an idle cycle
        SF: begin
          if (bit_cnt_d == target) adv = 1'b1;
          else if (sf_done[idx]) state_d = HUFF;
        end
        HUFF: if (bit_cnt_d == target) adv = 1'b1;
        default: ;
      endcase
      if (adv) begin
        bit_cnt_d = '0;
        frame_done_d = last;
        state_d = last ? IDLE : HOLD;
        if (!last) begin
          ch_d = (mono_q || ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
          gr_d = (mono_q || ch_q == CH_W'(NUM_CH - 1)) ? gr_q + 1'b1 : gr_q;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gr_q <= '0;
      ch_q <= '0;
      disc_cnt_q <= '0;
      num_disc_q <= '0;
      bit_cnt_q <= '0;
      p23_q <= '0;
      mono_q <= 1'b0;
      frame_done_q <= 1'b0;
      frame_skip_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gr_q <= gr_d;
      ch_q <= ch_d;
      disc_cnt_q <= disc_cnt_d;
      num_disc_q <= num_disc_d;
      bit_cnt_q <= bit_cnt_d;
      p23_q <= p23_d;
      mono_q <= mono_d;
      frame_done_q <= frame_done_d;
      frame_skip_q <= frame_skip_d;
    end
  end
`ifdef ROUTER_STATS_EN
  logic [15:0] skip_count_q, skip_count_d;
  logic [CNT_W-1:0] discard_total_q, discard_total_d;
  assign skip_count_d = skip_count_q + 16'(frame_skip_q && skip_count_q != '1);
  assign discard_total_d = discard_total_q + CNT_W'(res_discard_flag && fifo_dout_v);
  assign skip_count = skip_count_q;
  assign discard_total = discard_total_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      skip_count_q <= '0;
      discard_total_q <= '0;
    end else begin
      skip_count_q <= skip_count_d;
      discard_total_q <= discard_total_d;
    end
  end
`endif
endmodule
